// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: AXI4 read-burst instruction fetch controller.
//
// Issues sequential INCR bursts from a redirect PC, splitting at 4 KB boundaries and only
// when the beat buffer has room for the whole burst. Returned beats are stored in a
// first-word-fall-through FIFO and presented to the aligner over valid/ready. A redirect
// flushes the FIFO and drops beats of the burst still in flight. A non-OKAY response halts
// fetching after the burst completes, until the next redirect.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     new fetch stream (PC bits [31:1])
//   fetch_valid/ready/data/addr/err beat output to the aligner
//   busy                            burst outstanding or draining
//   axi_ar*                         AXI4 read address channel (master)
//   axi_r*                          AXI4 read data channel (master)
module ifu_fetch_ctrl #(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned FifoDepth  = 16,  // power of two, >= 2 and >= BurstLen
    parameter int unsigned BurstLen   = 8,
    parameter int unsigned AxiIdWidth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [30:0]           redirect_pc,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [DataWidth-1:0]  fetch_data,
    output logic [31:0]           fetch_addr,
    output logic                  fetch_err,
    output logic                  busy,
    output logic [AxiIdWidth-1:0] axi_arid,
    output logic [31:0]           axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [AxiIdWidth-1:0] axi_rid,
    input  logic [DataWidth-1:0]  axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam int unsigned Bytes   = DataWidth / 8;
    localparam int unsigned SizeLog = $clog2(Bytes);
    localparam int unsigned PtrW    = $clog2(FifoDepth);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned EntryW  = DataWidth + 33;
    localparam logic [31:0] AlignMask = ~(32'(Bytes) - 32'd1);

    typedef enum logic [2:0] {StIdle, StReq, StData, StDrain, StHalt} state_e;

    state_e            state_q, state_d;
    logic [31:0]       next_addr_q, next_addr_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              redir_pend_q, redir_pend_d;  // redirect seen while AR still pending
    logic              run_q, run_d;                // no fetching before the first redirect
    logic [31:0]       beat_addr_q, beat_addr_d;
    logic              burst_err_q, burst_err_d;
    logic [CntW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [EntryW-1:0] mem_q [FifoDepth];

    logic [31:0]     redir_addr;
    logic [31:0]     issue_addr;
    logic [12:0]     to_boundary;
    logic [12:0]     bnd_beats;
    logic [4:0]      issue_beats;
    logic [CntW-1:0] fifo_count;
    logic [CntW-1:0] fifo_free;
    logic            space_ok;
    logic            fifo_valid;
    logic            ar_hs;
    logic            r_hs;
    logic            rsp_err;
    logic            push;
    logic            pop;
    logic            load_req;
    logic [EntryW-1:0] head;
    logic            unused_rid;

    assign unused_rid = ^axi_rid;

    // Burst size for the address about to be issued: a redirect overrides next_addr.
    assign redir_addr  = {redirect_pc, 1'b0} & AlignMask;
    assign issue_addr  = redirect_valid ? redir_addr : next_addr_q;
    assign to_boundary = 13'd4096 - {1'b0, issue_addr[11:0]};
    assign bnd_beats   = to_boundary >> SizeLog;
    assign issue_beats = (bnd_beats < 13'(BurstLen)) ? 5'(bnd_beats) : 5'(BurstLen);

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_free  = CntW'(FifoDepth) - fifo_count;
    assign space_ok   = 32'(fifo_free) >= 32'(issue_beats);
    assign fifo_valid = (wr_ptr_q != rd_ptr_q);

    assign axi_arvalid = (state_q == StReq);
    assign axi_rready  = (state_q == StData) || (state_q == StDrain);
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_hs        = axi_rvalid && axi_rready;
    assign rsp_err     = (axi_rresp != 2'b00);
    assign pop         = fifo_valid && fetch_ready;

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        redir_pend_d = redir_pend_q;
        run_d        = run_q;
        beat_addr_d  = beat_addr_q;
        burst_err_d  = burst_err_q;
        push         = 1'b0;
        load_req     = 1'b0;

        if (redirect_valid) begin
            next_addr_d = redir_addr;
            run_d       = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // The redirect flushes the FIFO, so it never waits for space.
                if (redirect_valid || (run_q && space_ok)) begin
                    load_req = 1'b1;
                end
            end
            StReq: begin
                if (ar_hs) begin
                    if (redirect_valid || redir_pend_q) begin
                        // The accepted burst belongs to the old stream.
                        state_d      = StDrain;
                        redir_pend_d = 1'b0;
                    end else begin
                        state_d     = StData;
                        next_addr_d = araddr_q + ((32'(arlen_q) + 32'd1) << SizeLog);
                        beat_addr_d = araddr_q;
                        burst_err_d = 1'b0;
                    end
                end else if (redirect_valid) begin
                    redir_pend_d = 1'b1;
                end
            end
            StData: begin
                if (r_hs) begin
                    beat_addr_d = beat_addr_q + 32'(Bytes);
                    if (rsp_err) begin
                        burst_err_d = 1'b1;
                    end
                    push = !redirect_valid;
                    if (axi_rlast) begin
                        if (redirect_valid) begin
                            load_req = 1'b1;
                        end else begin
                            state_d = (burst_err_q || rsp_err) ? StHalt : StIdle;
                        end
                    end else if (redirect_valid) begin
                        state_d = StDrain;
                    end
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_hs && axi_rlast) begin
                    load_req = 1'b1;
                end
            end
            StHalt: begin
                if (redirect_valid) begin
                    load_req = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_req) begin
            state_d  = StReq;
            araddr_d = issue_addr;
            arlen_d  = 8'(issue_beats) - 8'd1;
        end
    end

    // Flush wins over push and pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + CntW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            next_addr_q  <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            redir_pend_q <= 1'b0;
            run_q        <= 1'b0;
            beat_addr_q  <= '0;
            burst_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            redir_pend_q <= redir_pend_d;
            run_q        <= run_d;
            beat_addr_q  <= beat_addr_d;
            burst_err_q  <= burst_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= {axi_rdata, beat_addr_q, rsp_err};
        end
    end

    // Head fields are gated so the outputs read zero while the FIFO is empty.
    assign head        = mem_q[rd_ptr_q[PtrW-1:0]];
    assign fetch_valid = fifo_valid;
    assign fetch_data  = fifo_valid ? head[EntryW-1 -: DataWidth] : '0;
    assign fetch_addr  = fifo_valid ? head[32:1] : '0;
    assign fetch_err   = fifo_valid ? head[0] : 1'b0;

    assign busy        = (state_q != StIdle) && (state_q != StHalt);
    assign axi_arid    = '0;
    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = 3'(SizeLog);
    assign axi_arburst = 2'b01;
    // Instruction-access protection; held at zero when no request is presented.
    assign axi_arprot  = axi_arvalid ? 3'b100 : 3'b000;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: scoreboard bench for ifu_fetch_ctrl (default parameters).
// An AXI slave model returns {~addr, addr} beats; expected beats are queued when the
// slave hands over a beat of a live burst and compared when the consumer pops.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [30:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_data;
    logic [31:0] fetch_addr;
    logic        fetch_err;
    logic        busy;
    logic [3:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [3:0]  axi_rid;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    always #5 clk = ~clk;

    ifu_fetch_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .fetch_addr     (fetch_addr),
        .fetch_err      (fetch_err),
        .busy           (busy),
        .axi_arid       (axi_arid),
        .axi_araddr     (axi_araddr),
        .axi_arlen      (axi_arlen),
        .axi_arsize     (axi_arsize),
        .axi_arburst    (axi_arburst),
        .axi_arprot     (axi_arprot),
        .axi_arvalid    (axi_arvalid),
        .axi_arready    (axi_arready),
        .axi_rid        (axi_rid),
        .axi_rdata      (axi_rdata),
        .axi_rresp      (axi_rresp),
        .axi_rlast      (axi_rlast),
        .axi_rvalid     (axi_rvalid),
        .axi_rready     (axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        bit          stale;
        int          err_idx;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } ar_t;

    burst_t      bq[$];      // bursts accepted by the slave, oldest first
    ar_t         good_ar[$]; // ARs of the live stream
    logic [96:0] sb[$];      // expected {err, addr, data}

    int n_checks = 0;
    int n_pass   = 0;
    int beat_i, ar_all, pops, err_pops, stale_drops, pops_at_ar;
    int redir_at_beat, pend_err;
    bit redir_req, stale_next, cons_rdy, ar_rdy_en, chk_empty;
    logic [31:0] redir_target, exp_next;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_beats(input logic [31:0] a);
        int rem;
        rem = (4096 - int'(a[11:0])) / 8;
        return (rem < 8) ? rem : 8;
    endfunction

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic model_reset();
        bq.delete();
        sb.delete();
        beat_i        = 0;
        stale_next    = 1'b0;
        chk_empty     = 1'b0;
        redir_req     = 1'b0;
        redir_at_beat = -1;
        pend_err      = -1;
    endtask

    // One clock cycle: observe at the negedge and drive inputs for the next posedge.
    task automatic step();
        bit          redir, r_fire, ar_fire, pop;
        logic [31:0] baddr;
        burst_t      nb;
        ar_t         ga;
        int          nbeats;
        @(negedge clk);
        if (chk_empty) begin
            check_eq("flush_empty", fetch_valid, 1'b0);
            chk_empty = 1'b0;
        end

        redir = 1'b0;
        if (redir_req) begin
            redir     = 1'b1;
            redir_req = 1'b0;
        end else if (redir_at_beat >= 0 && bq.size() > 0 && !bq[0].stale &&
                     beat_i == redir_at_beat) begin
            redir         = 1'b1;
            redir_at_beat = -1;
        end
        redirect_valid = redir;
        redirect_pc    = redir_target[31:1];

        baddr = '0;
        if (bq.size() > 0) begin
            baddr      = bq[0].addr + 32'(beat_i * 8);
            axi_rvalid = 1'b1;
            axi_rdata  = data_of(baddr);
            axi_rresp  = (beat_i == bq[0].err_idx) ? 2'b10 : 2'b00;
            axi_rlast  = (beat_i == bq[0].len);
        end else begin
            axi_rvalid = 1'b0;
            axi_rdata  = '0;
            axi_rresp  = 2'b00;
            axi_rlast  = 1'b0;
        end
        r_fire = axi_rvalid && axi_rready;

        axi_arready = ar_rdy_en;
        ar_fire     = axi_arvalid && axi_arready;

        fetch_ready = cons_rdy;
        pop = fetch_valid && fetch_ready && !redir;
        if (pop) begin
            pops++;
            if (fetch_err) err_pops++;
            if (sb.size() == 0) begin
                check_eq("beat_unexpected", fetch_valid, 1'b0);
            end else begin
                check_eq("beat", {fetch_err, fetch_addr, fetch_data}, sb.pop_front());
            end
        end

        if (r_fire) begin
            if (bq[0].stale || redir) begin
                stale_drops++;
            end else begin
                sb.push_back({(axi_rresp != 2'b00), baddr, axi_rdata});
            end
            if (axi_rlast) begin
                void'(bq.pop_front());
                beat_i = 0;
            end else begin
                beat_i++;
            end
        end

        if (redir) begin
            sb.delete();
            foreach (bq[i]) bq[i].stale = 1'b1;
            if (axi_arvalid) stale_next = 1'b1;
            exp_next  = redir_target & 32'hFFFF_FFF8;
            chk_empty = 1'b1;
        end

        if (ar_fire) begin
            ar_all++;
            nb.addr    = axi_araddr;
            nb.len     = int'(axi_arlen);
            nb.stale   = stale_next;
            nb.err_idx = -1;
            stale_next = 1'b0;
            if (!nb.stale) begin
                nb.err_idx = pend_err;
                pend_err   = -1;
                nbeats     = exp_beats(exp_next);
                check_eq("araddr", axi_araddr, exp_next);
                check_eq("arlen", axi_arlen, 8'(nbeats - 1));
                check_eq("arsize_prot", {axi_arsize, axi_arprot, axi_arburst}, {3'd3, 3'b100, 2'b01});
                exp_next   = exp_next + 32'(nbeats * 8);
                pops_at_ar = pops;
                ga.addr    = axi_araddr;
                ga.len     = int'(axi_arlen);
                good_ar.push_back(ga);
            end
            bq.push_back(nb);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_good_ar(input int n, input int budget);
        int c = 0;
        while (good_ar.size() < n && c < budget) begin
            step();
            c++;
        end
        check_eq("ar_wait", good_ar.size() >= n, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_axi"}, {axi_arvalid, axi_araddr, axi_arlen, axi_arprot, axi_arid, axi_rready},
                 '0);
        check_eq({tag, "_const"}, {axi_arsize, axi_arburst}, {3'd3, 2'b01});
        check_eq({tag, "_fetch"}, {fetch_valid, fetch_data, fetch_addr, fetch_err, busy}, '0);
    endtask

    initial begin
        int base, c, p0, d0, e0, a0;

        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_ready    = 1'b0;
        axi_arready    = 1'b0;
        axi_rid        = '0;
        axi_rdata      = '0;
        axi_rresp      = '0;
        axi_rlast      = 1'b0;
        axi_rvalid     = 1'b0;
        cons_rdy       = 1'b1;
        ar_rdy_en      = 1'b1;
        redir_target   = '0;
        exp_next       = '0;
        ar_all = 0; pops = 0; err_pops = 0; stale_drops = 0; pops_at_ar = 0;
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(5);
        check_eq("no_fetch_before_redirect", ar_all, 0);

        // Sequential stream from 0x1000.
        redir_target = 32'h1000;
        redir_req    = 1'b1;
        wait_good_ar(2, 60);
        c = 0;
        while (pops < 8 && c < 60) begin step(); c++; end
        check_eq("t1_pops", pops >= 8, 1'b1);
        check_eq("t1_ar0", {good_ar[0].addr, 8'(good_ar[0].len)}, {32'h1000, 8'd7});
        check_eq("t1_ar1", good_ar[1].addr, 32'h1040);

        // 4 KB split.
        base         = good_ar.size();
        redir_target = 32'h1FE0;
        redir_req    = 1'b1;
        wait_good_ar(base + 2, 80);
        check_eq("t2_ar0", {good_ar[base].addr, 8'(good_ar[base].len)}, {32'h1FE0, 8'd3});
        check_eq("t2_ar1", {good_ar[base + 1].addr, 8'(good_ar[base + 1].len)}, {32'h2000, 8'd7});

        // Consumer stalled: two bursts fill the FIFO.
        cons_rdy     = 1'b0;
        base         = good_ar.size();
        redir_target = 32'h4000;
        redir_req    = 1'b1;
        run(80);
        check_eq("t3_two_bursts", good_ar.size() - base, 2);
        p0       = pops;
        cons_rdy = 1'b1;
        wait_good_ar(base + 3, 100);
        check_eq("t3_pops_before_third", (pops_at_ar - p0) >= 8, 1'b1);

        // Redirect after 3 of 8 beats.
        d0            = stale_drops;
        redir_target  = 32'h8000;
        redir_at_beat = 3;
        c = 0;
        while (redir_at_beat != -1 && c < 100) begin step(); c++; end
        base = good_ar.size();
        wait_good_ar(base + 1, 60);
        check_eq("t4_new_ar", good_ar[base].addr, 32'h8000);
        check_eq("t4_dropped", stale_drops - d0, 5);
        run(20);

        // Error on beat 5 halts fetching.
        e0           = err_pops;
        base         = good_ar.size();
        pend_err     = 5;
        redir_target = 32'hA000;
        redir_req    = 1'b1;
        wait_good_ar(base + 1, 60);
        a0 = ar_all;
        run(40);
        check_eq("t5_no_ar_in_halt", ar_all - a0, 0);
        check_eq("t5_err_beat", err_pops - e0, 1);
        check_eq("t5_idle", {busy, fetch_valid}, 2'b00);
        redir_target = 32'hC000;
        redir_req    = 1'b1;
        wait_good_ar(base + 2, 40);
        check_eq("t5_resume", good_ar[base + 1].addr, 32'hC000);

        // Reset during DATA.
        base         = good_ar.size();
        redir_target = 32'hE000;
        redir_req    = 1'b1;
        c = 0;
        while (!(good_ar.size() > base && bq.size() > 0 && !bq[0].stale && beat_i >= 2) &&
               c < 80) begin
            step();
            c++;
        end
        check_eq("t6_in_data", axi_rready, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_reset");
        model_reset();
        redirect_valid = 1'b0;
        axi_rvalid     = 1'b0;
        axi_rlast      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a0    = ar_all;
        run(20);
        check_eq("t6_no_ar", ar_all - a0, 0);
        check_eq("t6_idle", {busy, fetch_valid}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Parametrised AXI4 read-burst instruction fetch controller for the IFU. It issues sequential INCR bursts starting from a redirect PC and buffers returned beats in an internal FIFO. It presents beats to the aligner over a valid/ready interface.
Compared with the single-burst fetch front end, it adds:
- configurable data width, depth and burst length
- space-checked burst issue
- 4 KB boundary splitting
- discard of stale in-flight beats after a redirect
- error-response capture

Parameters:
DataWidth, 64, AXI R data width in bits; legal values 32, 64, 128.
FifoDepth, 16, beat buffer entries; power of two, at least BurstLen.
BurstLen, 8, maximum beats per burst; 1..16.
AxiIdWidth, 4, AXI ID width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  new fetch stream request; single-cycle pulse
redirect_pc  in  31  target PC bits [31:1]
fetch_valid  out  1  buffered beat available
fetch_ready  in  1  consumer accepts beat
fetch_data  out  DataWidth  beat data
fetch_addr  out  32  byte address of beat (aligned to DataWidth/8)
fetch_err  out  1  beat returned with non-OKAY rresp
busy  out  1  burst outstanding or draining
axi_arid  out  AxiIdWidth  constant 0
axi_araddr  out  32  burst start address
axi_arlen  out  8  beats minus one
axi_arsize  out  3  log2(DataWidth/8)
axi_arburst  out  2  constant INCR
axi_arprot  out  3  constant 3'b100 (instruction access)
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rid  in  AxiIdWidth  ignored
axi_rdata  in  DataWidth  R data
axi_rresp  in  2  R response
axi_rlast  in  1  last beat
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready

Behaviour:
- Reset values: state IDLE; all outputs 0 except axi_arsize and axi_arburst, which hold their constant values; FIFO empty. The controller does not fetch until the first redirect.
- States:
  - IDLE
  - REQ: arvalid high
  - DATA: accepting beats
  - DRAIN: discarding stale beats
  - HALT: error seen; no further AR
- Redirect handling:
  - On redirect_valid: the FIFO is flushed that cycle.
  - next_addr <= redirect_pc aligned down to DataWidth/8 bytes.
  - From IDLE, DATA-complete or HALT: go to REQ.
  - From REQ before handshake: arvalid stays high with its old address until accepted, then go to DRAIN.
  - From DATA: go to DRAIN.
  - DRAIN keeps axi_rready=1, drops all beats, exits on the rlast handshake, then enters REQ with next_addr. It does not write the FIFO.
  - A redirect while already in DRAIN only updates next_addr.
- Burst issue:
  - REQ is entered only when FIFO free entries >= beats of the burst; otherwise wait in IDLE.
  - Beats = min(BurstLen, (4096 - next_addr[11:0]) / (DataWidth/8)).
  - axi_arlen = beats-1; axi_araddr = next_addr. Both are registered and stable while arvalid is high.
  - On AR handshake: next_addr += beats*(DataWidth/8), modulo 2^32; go to DATA.
- DATA:
  - axi_rready = 1. FIFO space is guaranteed by the issue check, so full never backpressures.
  - Each beat is written as {data, addr, err}. The beat address increments per beat from the burst start.
  - On the rlast handshake: go to HALT if any beat in the burst had rresp != 0, else IDLE.
- Only one burst is outstanding at a time. busy = (state != IDLE && state != HALT).
- FIFO and consumer side:
  - First-word-fall-through; fetch_* reflect the head entry.
  - Pop on fetch_valid && fetch_ready.
  - A simultaneous push and pop when full is not possible by construction; push and pop when empty behaves normally, with the beat visible the cycle after the push.
  - Redirect flush takes priority over push and pop in the same cycle.
- Errored beats are still delivered, with fetch_err=1. After HALT, only a redirect resumes fetching.

Test Plan:
- Reset, then redirect_pc=0x1000>>1 with fetch_ready=1 -> AR addr 0x1000, arlen 7, arsize 3; 8 beats out, fetch_addr 0x1000..0x1038; next AR at 0x1040.
- Redirect to 0x1FE0 -> first burst arlen 3 (ends at 4 KB boundary), next AR at 0x2000 with arlen 7.
- fetch_ready=0 with FifoDepth 16 and BurstLen 8 -> exactly two bursts issued; a third AR only after at least 8 pops.
- Redirect mid-burst after 3 of 8 beats -> FIFO empty next cycle; remaining 5 beats dropped; new AR issued after rlast; only new-stream beats are output.
- Beat 5 returned with rresp=2'b10 -> that beat is output with fetch_err=1, state HALT, no further AR; redirect then resumes fetching.
- Reset asserted during DATA -> all outputs return to reset values immediately; no AR until the next redirect.
